// File: rtl/cond_logic.sv
// cond_logic: conditional-execution unit that gates PC/register/memory writes on a
// condition code and holds the architectural {N,Z,C,V} flags. Optional COND_STATS_EN macro adds execute/squash counters.
module cond_logic #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  input  logic             Stall,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
`ifdef COND_STATS_EN
  output logic [CNT_W-1:0] ExecCount,
  output logic [CNT_W-1:0] SquashCount,
`endif
  output logic [3:0]       Flags
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("cond_logic: CNT_W must be at least 1");
  end

  // Condition-code evaluation against {N,Z,C,V}; encoding 1111 is unsupported and never passes.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    logic pass;
    {n, z, c, v} = flags;
    case (cond)
      4'b0000: pass = z;
      4'b0001: pass = ~z;
      4'b0010: pass = c;
      4'b0011: pass = ~c;
      4'b0100: pass = n;
      4'b0101: pass = ~n;
      4'b0110: pass = v;
      4'b0111: pass = ~v;
      4'b1000: pass = c & ~z;
      4'b1001: pass = ~c | z;
      4'b1010: pass = (n == v);
      4'b1011: pass = (n != v);
      4'b1100: pass = ~z & (n == v);
      4'b1101: pass = z | (n != v);
      4'b1110: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

  logic [1:0] flags_nz_q, flags_nz_d;
  logic [1:0] flags_cv_q, flags_cv_d;
  logic       cond_ex_s;
  logic       upd_en_s;

  assign Flags = {flags_nz_q, flags_cv_q};

  // Write gating is purely combinational; Stall only freezes state, never these strobes.
  always_comb begin
    cond_ex_s = cond_eval(Cond, {flags_nz_q, flags_cv_q});
    CondEx    = cond_ex_s;
    PCSrc     = PCS & cond_ex_s;
    MemWrite  = MemW & cond_ex_s;
    RegWrite  = RegW & cond_ex_s & ~NoWrite;
    upd_en_s  = cond_ex_s & ~Stall;
  end

  // Each flag group loads independently; squashed or stalled instructions leave flags untouched.
  always_comb begin
    flags_nz_d = flags_nz_q;
    flags_cv_d = flags_cv_q;
    if (FlagW[1] && upd_en_s) begin
      flags_nz_d = ALUFlags[3:2];
    end else begin
      flags_nz_d = flags_nz_q;
    end
    if (FlagW[0] && upd_en_s) begin
      flags_cv_d = ALUFlags[1:0];
    end else begin
      flags_cv_d = flags_cv_q;
    end
  end

  // Flag register; reset wins over any pending write in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_nz_q <= 2'b00;
      flags_cv_q <= 2'b00;
    end else begin
      flags_nz_q <= flags_nz_d;
      flags_cv_q <= flags_cv_d;
    end
  end

`ifdef COND_STATS_EN
  logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
  logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

  assign ExecCount   = exec_cnt_q;
  assign SquashCount = squash_cnt_q;

  // Counters wrap naturally at 2^CNT_W.
  always_comb begin
    exec_cnt_d   = exec_cnt_q;
    squash_cnt_d = squash_cnt_q;
    if (Stall) begin
      exec_cnt_d   = exec_cnt_q;
      squash_cnt_d = squash_cnt_q;
    end else if (cond_ex_s) begin
      exec_cnt_d   = exec_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      squash_cnt_d = squash_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      exec_cnt_q   <= {CNT_W{1'b0}};
      squash_cnt_q <= {CNT_W{1'b0}};
    end else begin
      exec_cnt_q   <= exec_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_cond_logic.sv
// Table-driven bench for cond_logic; counter checks compile in when COND_STATS_EN is defined.
module tb_cond_logic;

`ifdef COND_STATS_EN
  localparam int TB_CNT_W = 4;
`else
  localparam int TB_CNT_W = 32;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, NoWrite, Stall;
  logic       PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0] Flags;
`ifdef COND_STATS_EN
  logic [TB_CNT_W-1:0] ExecCount, SquashCount;
`endif

  cond_logic #(.CNT_W(TB_CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .Cond       (Cond),
    .ALUFlags   (ALUFlags),
    .FlagW      (FlagW),
    .PCS        (PCS),
    .RegW       (RegW),
    .MemW       (MemW),
    .NoWrite    (NoWrite),
    .Stall      (Stall),
    .PCSrc      (PCSrc),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .CondEx     (CondEx),
`ifdef COND_STATS_EN
    .ExecCount  (ExecCount),
    .SquashCount(SquashCount),
`endif
    .Flags      (Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] cond;
    logic [3:0] alu;
    logic [1:0] flagw;
    logic       pcs, regw, memw, nowr, stall;
    logic       ex, pcsrc, regwr, memwr;
    logic [3:0] flags;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_miss = 0;

  function automatic vec_t mk(input logic rst, input logic [3:0] cond, input logic [3:0] alu,
                              input logic [1:0] flagw, input logic pcs, input logic regw,
                              input logic memw, input logic nowr, input logic stall,
                              input logic ex, input logic pcsrc, input logic regwr,
                              input logic memwr, input logic [3:0] flags);
    vec_t v;
    v.rst = rst; v.cond = cond; v.alu = alu; v.flagw = flagw;
    v.pcs = pcs; v.regw = regw; v.memw = memw; v.nowr = nowr; v.stall = stall;
    v.ex = ex; v.pcsrc = pcsrc; v.regwr = regwr; v.memwr = memwr; v.flags = flags;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; Cond = v.cond; ALUFlags = v.alu; FlagW = v.flagw;
    PCS = v.pcs; RegW = v.regw; MemW = v.memw; NoWrite = v.nowr; Stall = v.stall;
  endtask

  initial begin
    //            rst cond     alu      fw     pcs  rw   mw   nw   st   ex   pc   rwo  mwo  flags-after
    vecs.push_back(mk(0, 4'h0, 4'h0, 2'b00, 1, 0, 0, 0, 0,  0, 0, 0, 0, 4'b0000)); // EQ fails after reset
    vecs.push_back(mk(0, 4'h1, 4'h0, 2'b00, 1, 0, 0, 0, 0,  1, 1, 0, 0, 4'b0000)); // NE passes
    vecs.push_back(mk(0, 4'h2, 4'h0, 2'b00, 0, 1, 0, 0, 0,  0, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(0, 4'h3, 4'h0, 2'b00, 0, 1, 1, 0, 0,  1, 0, 1, 1, 4'b0000));
    vecs.push_back(mk(0, 4'h4, 4'h0, 2'b00, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(0, 4'h5, 4'h0, 2'b00, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(0, 4'h6, 4'h0, 2'b00, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(0, 4'h7, 4'h0, 2'b00, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(0, 4'h8, 4'h0, 2'b00, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(0, 4'h9, 4'h0, 2'b00, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(0, 4'hA, 4'h0, 2'b00, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(0, 4'hB, 4'h0, 2'b00, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(0, 4'hC, 4'h0, 2'b00, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(0, 4'hD, 4'h0, 2'b00, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(0, 4'hF, 4'h0, 2'b11, 1, 1, 1, 0, 0,  0, 0, 0, 0, 4'b0000)); // 1111 squashed
    vecs.push_back(mk(0, 4'hE, 4'h4, 2'b11, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4'b0100)); // AL sets Z
    vecs.push_back(mk(0, 4'h0, 4'h0, 2'b00, 0, 1, 0, 0, 0,  1, 0, 1, 0, 4'b0100)); // EQ now passes
    vecs.push_back(mk(0, 4'h1, 4'hA, 2'b11, 0, 0, 1, 0, 0,  0, 0, 0, 0, 4'b0100)); // squashed write
    vecs.push_back(mk(0, 4'h9, 4'h0, 2'b00, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4'b0100));
    vecs.push_back(mk(0, 4'h8, 4'h0, 2'b00, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4'b0100));
    vecs.push_back(mk(0, 4'hD, 4'h0, 2'b00, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4'b0100));
    vecs.push_back(mk(0, 4'hC, 4'h0, 2'b00, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4'b0100));
    vecs.push_back(mk(1, 4'hE, 4'hF, 2'b11, 1, 0, 0, 0, 0,  1, 1, 0, 0, 4'b0000)); // reset drops write
    vecs.push_back(mk(0, 4'hE, 4'hF, 2'b10, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4'b1100)); // N,Z group only
    vecs.push_back(mk(0, 4'hE, 4'h3, 2'b01, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4'b1111)); // C,V group only
    vecs.push_back(mk(0, 4'h8, 4'h0, 2'b00, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4'b1111)); // HI with Z=1
    vecs.push_back(mk(0, 4'hA, 4'h0, 2'b00, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4'b1111));
    vecs.push_back(mk(0, 4'hB, 4'h0, 2'b11, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4'b1111));
    vecs.push_back(mk(0, 4'hE, 4'h9, 2'b11, 0, 1, 0, 0, 1,  1, 0, 1, 0, 4'b1111)); // stall freezes flags
    vecs.push_back(mk(0, 4'hE, 4'h0, 2'b00, 0, 1, 0, 1, 1,  1, 0, 0, 0, 4'b1111)); // NoWrite
    vecs.push_back(mk(0, 4'h0, 4'h0, 2'b01, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4'b1100));
    vecs.push_back(mk(0, 4'h2, 4'h0, 2'b00, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4'b1100));
    vecs.push_back(mk(0, 4'h4, 4'h6, 2'b10, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4'b0100));
    vecs.push_back(mk(0, 4'hF, 4'h0, 2'b00, 0, 0, 1, 0, 0,  0, 0, 0, 0, 4'b0100));

    // Initial reset: Flags must clear regardless of Stall/FlagW.
    drive(mk(1, 4'hE, 4'hF, 2'b11, 0, 0, 0, 0, 1,  0, 0, 0, 0, 4'b0000));
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    check("reset_flags", -1, {28'd0, Flags}, 32'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      n_vec++;
      check("CondEx",   i, {31'd0, CondEx},   {31'd0, vecs[i].ex});
      check("PCSrc",    i, {31'd0, PCSrc},    {31'd0, vecs[i].pcsrc});
      check("RegWrite", i, {31'd0, RegWrite}, {31'd0, vecs[i].regwr});
      check("MemWrite", i, {31'd0, MemWrite}, {31'd0, vecs[i].memwr});
      @(posedge clk);
      #1;
      check("Flags",    i, {28'd0, Flags},    {28'd0, vecs[i].flags});
    end

`ifdef COND_STATS_EN
    @(negedge clk);
    drive(mk(1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4'b0000));
    @(posedge clk);
    #1;
    n_vec++;
    check("exec_after_reset", 100, {28'd0, ExecCount},   32'h0);
    check("squash_after_reset", 100, {28'd0, SquashCount}, 32'h0);
    reset = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    n_vec++;
    check("exec_wrap", 101, {28'd0, ExecCount},   32'h1);
    check("squash_idle", 101, {28'd0, SquashCount}, 32'h0);
    @(negedge clk);
    Cond = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    Stall = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    check("squash_count", 102, {28'd0, SquashCount}, 32'h3);
    check("exec_hold", 102, {28'd0, ExecCount},   32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    check("exec_cleared", 103, {28'd0, ExecCount},   32'h0);
    check("squash_cleared", 103, {28'd0, SquashCount}, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cond_logic.md
COND_LOGIC -- requirements
Module: cond_logic

Interface
REQ-001 Parameter CNT_W, default 32: width of the optional execute/squash counters.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Cond  input  4  instruction condition field, Instr[31:28].
REQ-005 ALUFlags  input  4  {N,Z,C,V} from the ALU for the current instruction.
REQ-006 FlagW  input  2  flag-write request; bit1 = N,Z group, bit0 = C,V group.
REQ-007 PCS  input  1  decoder request to write PC.
REQ-008 RegW  input  1  decoder request to write register file.
REQ-009 MemW  input  1  decoder request to write data memory.
REQ-010 NoWrite  input  1  compare-class op (CMP/CMN/TST/TEQ); suppresses RegWrite.
REQ-011 Stall  input  1  hold; flags and counters frozen while high.
REQ-012 PCSrc  output  1  gated PC write.
REQ-013 RegWrite  output  1  gated register write.
REQ-014 MemWrite  output  1  gated memory write.
REQ-015 CondEx  output  1  condition-passed indication for current instruction.
REQ-016 Flags  output  4  current architectural {N,Z,C,V} register.
REQ-017 ExecCount, SquashCount  output  CNT_W each  present only with COND_STATS_EN.

Function
REQ-018 CondEx SHALL be combinational from Cond and registered Flags (not ALUFlags): EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C; MI 0100 N; PL 0101 !N; VS 0110 V; VC 0111 !V; HI 1000 C&!Z; LS 1001 !C|Z; GE 1010 N==V; LT 1011 N!=V; GT 1100 !Z&(N==V); LE 1101 Z|(N!=V); AL 1110 1.
REQ-019 Cond 1111 SHALL yield CondEx=0 (unsupported encoding squashed; no X propagation).
REQ-020 PCSrc = PCS&CondEx; MemWrite = MemW&CondEx; RegWrite = RegW&CondEx&!NoWrite; zero cycle latency.
REQ-021 Flags[3:2] SHALL load ALUFlags[3:2] at rising edge iff FlagW[1]&CondEx&!Stall; else hold.
REQ-022 Flags[1:0] SHALL load ALUFlags[1:0] at rising edge iff FlagW[0]&CondEx&!Stall; else hold.
REQ-023 FlagW=11 SHALL update all four bits in the same edge; groups independent otherwise.
REQ-024 A squashed instruction (CondEx=0) SHALL NOT modify Flags even with FlagW set.
REQ-025 Flag update SHALL be visible to CondEx of the next instruction only (one-cycle latency, no ALUFlags bypass).
REQ-026 Stall SHALL NOT gate PCSrc/RegWrite/MemWrite/CondEx; only state updates.

Reset
REQ-027 reset high at a rising edge SHALL set Flags=4'b0000 and, if compiled in, ExecCount=SquashCount=0, overriding Stall and FlagW.
REQ-028 During reset, outputs SHALL remain combinational from inputs and current Flags; after reset EQ fails, NE passes.
REQ-029 Reset asserted mid-sequence SHALL discard any pending flag write in that cycle.

Configuration
REQ-030 Macro COND_STATS_EN defined: ExecCount increments per non-stalled, non-reset cycle with CondEx=1; SquashCount per such cycle with CondEx=0; both wrap modulo 2^CNT_W.
REQ-031 COND_STATS_EN undefined: counter ports and registers SHALL be absent; all other behaviour identical.

Verification
REQ-032 Reset; Cond=0000, PCS=1 -> CondEx=0, PCSrc=0; Cond=0001 -> CondEx=1, PCSrc=1.
REQ-033 Cond=1110, FlagW=11, ALUFlags=0100, edge -> Flags=0100; next Cond=0000 RegW=1 -> RegWrite=1.
REQ-034 Flags=0100; Cond=0001, FlagW=11, ALUFlags=1010, MemW=1 -> MemWrite=0, Flags stays 0100.
REQ-035 Flags=0000; Cond=1110, FlagW=10, ALUFlags=1111 -> Flags=1100; then FlagW=01, ALUFlags=0011 -> Flags=1111; Cond=1000 -> CondEx=0.
REQ-036 Stall=1, Cond=1110, FlagW=11, ALUFlags=1001 -> Flags unchanged, RegWrite=RegW; NoWrite=1, RegW=1 -> RegWrite=0.
REQ-037 With COND_STATS_EN, CNT_W=4: 17 passing cycles -> ExecCount=1; 3 squashed -> SquashCount=3; reset -> both 0.
